// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the PC unit with return-address stack.
package pc_unit_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam int          DEF_PC_INC       = 4;

    typedef enum logic [1:0] {
        RAS_NOP  = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_SWAP = 2'd3
    } ras_op_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: ptr addresses the top entry, count saturates at DEPTH.
module ras_stack
    import pc_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  ras_op_e          op_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign top_o   = empty_o ? '0 : mem_q[ptr_q];
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q + PW'(1);
        case (op_i)
            RAS_PUSH, RAS_SWAP: begin
                if (op_i == RAS_SWAP && !empty_o) begin
                    // Replace the top in place; depth is unchanged.
                    wr_en  = 1'b1;
                    wr_idx = ptr_q;
                end else begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PW'(1);
                    if (full_o) ovf_d = 1'b1;
                    else        count_d = count_q + CW'(1);
                    if (op_i == RAS_SWAP) unf_d = 1'b1;
                end
            end
            RAS_POP: begin
                if (empty_o) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d   = ptr_q - PW'(1);
                    count_d = count_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[wr_idx] <= push_data_i;
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with branch enable, exception redirect, EPC and return-address stack.
// Define PC_ALIGN_CHECK_EN to add the misalign output and suppress misaligned PC loads.
module pc_unit_ras
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               PC_INC       = DEF_PC_INC,
    parameter int               RAS_DEPTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             zero,
    input  logic             exc,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] epc_q,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic             ras_unf
);

    logic             en;
    logic             pop_take;
    logic             bad_align;
    logic             load;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_d, epc_d;
    ras_op_e          op;

    always_comb begin
        en       = pc_write | (pc_write_cond & zero);
        pop_take = en & ras_pop & ~ras_empty;
        target   = pop_take ? ras_top : pc_next;
`ifdef PC_ALIGN_CHECK_EN
        bad_align = en & ~exc & (target[1:0] != 2'b00);
`else
        bad_align = 1'b0;
`endif
        // Exceptions and suppressed loads leave the stack alone.
        load = en & ~exc & ~bad_align;

        op = RAS_NOP;
        if (load) begin
            case ({ras_push, ras_pop})
                2'b10:   op = RAS_PUSH;
                2'b01:   op = RAS_POP;
                2'b11:   op = RAS_SWAP;
                default: op = RAS_NOP;
            endcase
        end

        pc_d  = pc_q;
        epc_d = epc_q;
        if (exc) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (load) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= bad_align;
    end
`endif

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .op_i        (op),
        .push_data_i (pc_q + WIDTH'(PC_INC)),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .ovf_o       (ras_ovf),
        .unf_o       (ras_unf)
    );

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: driver queues hand-computed expectations, monitor compares.
module tb_pc_unit_ras;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] pc_next = '0;
    logic         pc_write = 1'b0, pc_write_cond = 1'b0, zero = 1'b0, exc = 1'b0;
    logic         ras_push = 1'b0, ras_pop = 1'b0;
    logic [W-1:0] pc_q, epc_q, ras_top;
    logic         ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    always #5 clk = ~clk;

    pc_unit_ras dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .exc           (exc),
        .ras_push      (ras_push),
        .ras_pop       (ras_pop),
        .pc_q          (pc_q),
        .epc_q         (epc_q),
        .ras_top       (ras_top),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_ovf       (ras_ovf),
`ifdef PC_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .ras_unf       (ras_unf)
    );

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] epc;
        logic [W-1:0] top;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         unf;
        logic         mis;
    } exp_t;

    exp_t exp_q[$];
    exp_t ex;
    int   checks = 0;
    int   passed = 0;
    int   step_no = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", step_no, name, act, exp);
    endtask

    // Inputs change on the falling edge; the expectation describes the state after the next rising edge.
    task automatic drive(input logic rst, input logic [W-1:0] nxt, input logic wr, input logic wc,
                         input logic z, input logic ex_in, input logic push, input logic pop);
        @(negedge clk);
        reset = rst; pc_next = nxt; pc_write = wr; pc_write_cond = wc;
        zero = z; exc = ex_in; ras_push = push; ras_pop = pop;
        exp_q.push_back(ex);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                step_no++;
                check("pc_q", pc_q, e.pc);
                check("epc_q", epc_q, e.epc);
                check("ras_top", ras_top, e.top);
                check("ras_empty", W'(ras_empty), W'(e.empty));
                check("ras_full", W'(ras_full), W'(e.full));
                check("ras_ovf", W'(ras_ovf), W'(e.ovf));
                check("ras_unf", W'(ras_unf), W'(e.unf));
`ifdef PC_ALIGN_CHECK_EN
                check("misalign", W'(misalign), W'(e.mis));
`endif
            end
        end
    end

    initial begin : stimulus
        ex = '{pc: 32'h0, epc: 32'h0, top: 32'h0, empty: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0, mis: 1'b0};

        // Reset holds PC at the reset vector despite pc_write.
        drive(1'b0, 32'h40, 1, 0, 0, 0, 0, 0);
        drive(1'b0, 32'h40, 1, 0, 0, 0, 0, 0);
        ex.pc = 32'h40;
        drive(1'b1, 32'h40, 1, 0, 0, 0, 0, 0);

        // Branch-conditional write.
        drive(1'b1, 32'h80, 0, 1, 0, 0, 0, 0);
        ex.pc = 32'h80;
        drive(1'b1, 32'h80, 0, 1, 1, 0, 0, 0);

        // Call then return.
        ex.pc = 32'h100;
        drive(1'b1, 32'h100, 1, 0, 0, 0, 0, 0);
        ex.pc = 32'h400; ex.top = 32'h104; ex.empty = 1'b0;
        drive(1'b1, 32'h400, 1, 0, 0, 0, 1, 0);
        ex.pc = 32'h104; ex.top = 32'h0; ex.empty = 1'b1;
        drive(1'b1, 32'h500, 1, 0, 0, 0, 0, 1);

        // Nine pushes: the first pushes 0x108, then 0x1004, 0x1014, ... 0x1074; the ninth overwrites 0x108.
        for (int i = 0; i < 9; i++) begin
            ex.top   = (i == 0) ? 32'h108 : 32'h1004 + 32'(i - 1) * 32'h10;
            ex.pc    = 32'h1000 + 32'(i) * 32'h10;
            ex.empty = 1'b0;
            ex.full  = (i >= 7);
            ex.ovf   = (i == 8);
            drive(1'b1, 32'h1000 + 32'(i) * 32'h10, 1, 0, 0, 0, 1, 0);
        end

        // Eight pops in LIFO order.
        for (int j = 0; j < 8; j++) begin
            ex.pc    = 32'h1074 - 32'(j) * 32'h10;
            ex.full  = 1'b0;
            ex.top   = (j < 7) ? 32'h1074 - 32'(j + 1) * 32'h10 : 32'h0;
            ex.empty = (j == 7);
            drive(1'b1, 32'hdead_0000, 1, 0, 0, 0, 0, 1);
        end

        // Pop while empty: PC takes pc_next, underflow sticks.
        ex.pc = 32'h300; ex.unf = 1'b1;
        drive(1'b1, 32'h300, 1, 0, 0, 0, 0, 1);

        // Exception with push and pop asserted leaves the stack alone.
        ex.pc = 32'h200;
        drive(1'b1, 32'h200, 1, 0, 0, 0, 0, 0);
        ex.top = 32'h204; ex.empty = 1'b0;
        drive(1'b1, 32'h200, 1, 0, 0, 0, 1, 0);
        ex.pc = 32'h180; ex.epc = 32'h200;
        drive(1'b1, 32'h600, 1, 0, 0, 1, 1, 1);

        // Push+pop on a non-empty stack replaces the top.
        ex.pc = 32'h204; ex.top = 32'h184;
        drive(1'b1, 32'h600, 1, 0, 0, 0, 1, 1);
        ex.pc = 32'h184; ex.top = 32'h0; ex.empty = 1'b1;
        drive(1'b1, 32'h640, 1, 0, 0, 0, 0, 1);

        // Push+pop on an empty stack acts as a push.
        ex.pc = 32'h700; ex.top = 32'h188; ex.empty = 1'b0;
        drive(1'b1, 32'h700, 1, 0, 0, 0, 1, 1);

        // No enable: push ignored, PC holds.
        drive(1'b1, 32'h800, 0, 0, 0, 0, 1, 0);

`ifdef PC_ALIGN_CHECK_EN
        ex.mis = 1'b1;
        drive(1'b1, 32'h202, 1, 0, 0, 0, 1, 0);
        ex.mis = 1'b0; ex.pc = 32'h204;
        drive(1'b1, 32'h204, 1, 0, 0, 0, 0, 0);
`else
        ex.pc = 32'h202;
        drive(1'b1, 32'h202, 1, 0, 0, 0, 0, 0);
        ex.pc = 32'h204;
        drive(1'b1, 32'h204, 1, 0, 0, 0, 0, 0);
`endif

        // Reset mid-operation discards the pending push and clears sticky flags.
        ex = '{pc: 32'h0, epc: 32'h0, top: 32'h0, empty: 1'b1, full: 1'b0, ovf: 1'b0, unf: 1'b0, mis: 1'b0};
        drive(1'b0, 32'h900, 1, 0, 0, 0, 1, 0);
        drive(1'b1, 32'h0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised successor to the multicycle datapath's plain enabled PC register.
- Holds the program counter with unconditional and branch-conditional write enables, an exception redirect, and an EPC capture register.
- Adds a circular return-address stack (RAS) for call/return.
- Sits between the multicycle control FSM and the instruction-memory address mux.

Parameters:
- WIDTH, 32, PC/data width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception.
- PC_INC, 4, return-address offset added to pc_q on push.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_next  in  WIDTH  candidate next PC from the datapath mux.
- pc_write  in  1  unconditional PC write enable.
- pc_write_cond  in  1  branch write enable, qualified by zero.
- zero  in  1  ALU zero flag.
- exc  in  1  exception request.
- ras_push  in  1  call: push pc_q+PC_INC (applied only when the PC updates).
- ras_pop  in  1  return: PC loads ras_top instead of pc_next (applied only when the PC updates).
- pc_q  out  WIDTH  registered PC.
- epc_q  out  WIDTH  registered exception PC.
- ras_top  out  WIDTH  combinational top-of-stack entry; 0 when empty.
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: a push occurred while full.
- ras_unf  out  1  sticky: a pop occurred while empty.

Behaviour:
- All register updates are synchronous to the rising edge of clk.
- Reset (reset==0), which overrides everything:
  - pc_q=RESET_VECTOR, epc_q=0.
  - RAS pointer and count cleared; ras_empty=1, ras_full=0.
  - ras_ovf=0, ras_unf=0.
  - Reset mid-operation discards any pending push or pop.
- Update enable: en = pc_write | (pc_write_cond & zero).
- Priority, highest first:
  - exc: pc_q<=EXC_VECTOR, epc_q<=pc_q. RAS is untouched; push/pop are ignored whether or not en is set.
  - en & ras_pop & !ras_empty: pc_q<=ras_top.
  - en: pc_q<=pc_next.
  - Otherwise pc_q holds.
- Latency: a new pc_q is visible one cycle after the enabling edge, and ras_top updates in that same cycle.
- RAS actions occur only when en=1 and exc=0:
  - Push only: write pc_q+PC_INC (modulo 2^WIDTH) at ptr+1, ptr++, count=min(count+1,RAS_DEPTH).
  - Push while full: wraps around and overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf<=1.
  - Pop only, not empty: ptr--, count--.
  - Pop while empty: pointer and count unchanged, PC takes pc_next, ras_unf<=1.
  - Push and pop together, not empty: PC takes the old ras_top; the top entry is replaced by pc_q+PC_INC; ptr and count unchanged.
  - Push and pop together, empty: treated as push only, and ras_unf<=1.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
- ras_ovf and ras_unf clear only on reset.

Optional Feature:
- PC_ALIGN_CHECK_EN defined:
  - Adds output misalign (1 bit, reset 0).
  - Any PC load whose target has bits [1:0]!=0 is suppressed; pc_q holds.
  - Such a load sets misalign to 1 for exactly one cycle.
  - RAS actions of that cycle are also suppressed.
  - Exception loads are never checked.
- Undefined: no port is added and no check is made; misaligned targets load normally.

Decomposition:
- Package pc_unit_pkg holds:
  - the default RESET_VECTOR, EXC_VECTOR and PC_INC constants;
  - a typedef for the RAS operation enum: RAS_NOP, RAS_PUSH, RAS_POP, RAS_SWAP.
- One sub-module, ras_stack: circular buffer, pointer, count, flags and sticky error bits.
- pc_unit_ras owns the PC/EPC registers, priority logic and operation decode.

Test Plan:
- Reset, then pc_write=1, pc_next=0x40 -> pc_q=0x0 during reset, 0x40 one cycle after release; all flags 0 and ras_empty=1.
- pc_write_cond=1 with zero=0 and pc_next=0x80 -> pc_q holds; with zero=1 -> pc_q=0x80.
- pc_q=0x100, push with en, pc_next=0x400 -> pc_q=0x400, ras_top=0x104; then pop with en -> pc_q=0x104, ras_empty=1.
- Nine pushes with RAS_DEPTH=8 -> ras_full=1, ras_ovf=1; eight pops return the newest 8 entries in LIFO order; the ninth pop sets ras_unf=1 and PC takes pc_next.
- exc=1 while pc_q=0x200 with push and pop asserted -> pc_q=0x180, epc_q=0x200, RAS unchanged.
- With PC_ALIGN_CHECK_EN: pc_write with pc_next=0x202 -> pc_q holds and misalign pulses for one cycle; a following pc_next=0x204 loads normally.
